// File: rtl/tilt_pulse_scheduler.sv
// Tilt-to-move-pulse scheduler: two-stage magnitude/level pipeline, per-axis tick
// counters and an X/Y pulse arbiter. Define TILT_HYST_EN to enable level hysteresis.
module tilt_pulse_scheduler #(
  parameter int DATA_W   = 9,
  parameter int CLK_HZ   = 100000000,
  parameter int THRESH_1 = 12,
  parameter int THRESH_2 = 20,
  parameter int THRESH_3 = 28,
  parameter int THRESH_4 = 40,
  parameter int FREQ_1   = 7,
  parameter int FREQ_2   = 23,
  parameter int FREQ_3   = 47,
  parameter int FREQ_4   = 95,
  parameter int STAGGER  = 100,
  parameter int HYST     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] accel_x_in,
  input  logic [DATA_W-1:0] accel_y_in,
  output logic [3:0]        x_thresh_level,
  output logic [3:0]        y_thresh_level,
  output logic [3:0]        move_pulses,
  output logic              pending
);

  localparam int MAG_W = DATA_W - 1;

  localparam logic [31:0] PERIOD_1 = 32'(CLK_HZ / FREQ_1 - 1);
  localparam logic [31:0] PERIOD_2 = 32'(CLK_HZ / FREQ_2 - 1);
  localparam logic [31:0] PERIOD_3 = 32'(CLK_HZ / FREQ_3 - 1);
  localparam logic [31:0] PERIOD_4 = 32'(CLK_HZ / FREQ_4 - 1);
  localparam logic [31:0] STAGGER_P = 32'(STAGGER);

`ifdef TILT_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  // Sign 0 means the low field counts down from full scale, so invert it.
  function automatic logic [MAG_W-1:0] mag_of(input logic [DATA_W-1:0] s);
    return s[DATA_W-1] ? s[MAG_W-1:0] : ~s[MAG_W-1:0];
  endfunction

  function automatic logic [2:0] raw_level(input logic [MAG_W-1:0] m);
    if (int'(m) < THRESH_1)      return 3'd0;
    else if (int'(m) < THRESH_2) return 3'd1;
    else if (int'(m) < THRESH_3) return 3'd2;
    else if (int'(m) < THRESH_4) return 3'd3;
    else                         return 3'd4;
  endfunction

  function automatic int lower_thresh(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return THRESH_1;
      3'd2:    return THRESH_2;
      3'd3:    return THRESH_3;
      3'd4:    return THRESH_4;
      default: return 0;
    endcase
  endfunction

  // Raising is immediate; lowering waits until the magnitude clears the margin.
  function automatic logic [2:0] next_level(input logic [MAG_W-1:0] m,
                                            input logic [2:0]       cur);
    logic [2:0] raw;
    raw = raw_level(m);
    if (!HYST_ON || raw >= cur)                   return raw;
    else if (int'(m) < lower_thresh(cur) - HYST)  return raw;
    else                                          return cur;
  endfunction

  function automatic logic [3:0] therm(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] period_of(input logic [2:0] lvl);
    case (lvl)
      3'd1:    return PERIOD_1;
      3'd2:    return PERIOD_2;
      3'd3:    return PERIOD_3;
      default: return PERIOD_4;
    endcase
  endfunction

  logic             sign_x, sign_y;
  logic [MAG_W-1:0] mag_x, mag_y;
  logic [2:0]       lvl_x, lvl_y;
  logic [31:0]      cnt_x, act_x, nxt_x;
  logic [31:0]      cnt_y, act_y, nxt_y;
  logic             pend_x, pend_x_dir, pend_y_dir;
  logic             req_x, req_y;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values and the pipeline stages stay exactly one cycle apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_x         <= 1'b0;
      sign_y         <= 1'b0;
      mag_x          <= '0;
      mag_y          <= '0;
      lvl_x          <= 3'd0;
      lvl_y          <= 3'd0;
      x_thresh_level <= 4'b0000;
      y_thresh_level <= 4'b0000;
    end else begin
      sign_x         <= accel_x_in[DATA_W-1];
      sign_y         <= accel_y_in[DATA_W-1];
      mag_x          <= mag_of(accel_x_in);
      mag_y          <= mag_of(accel_y_in);
      lvl_x          <= next_level(mag_x, lvl_x);
      lvl_y          <= next_level(mag_y, lvl_y);
      x_thresh_level <= therm(next_level(mag_x, lvl_x));
      y_thresh_level <= therm(next_level(mag_y, lvl_y));
    end
  end

  assign req_x = enable && (cnt_x == act_x) && (lvl_x != 3'd0);
  assign req_y = enable && (cnt_y == act_y) && (lvl_y != 3'd0);

  // The active period only reloads on a tick, so rate changes never cut a period short.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_x <= '0;
      act_x <= '0;
      nxt_x <= '0;
      cnt_y <= '0;
      act_y <= STAGGER_P;
      nxt_y <= STAGGER_P;
    end else begin
      if (lvl_x != 3'd0) nxt_x <= period_of(lvl_x);
      if (lvl_y != 3'd0) nxt_y <= period_of(lvl_y);
      if (enable) begin
        if (cnt_x == act_x) begin
          cnt_x <= '0;
          act_x <= nxt_x;
        end else begin
          cnt_x <= cnt_x + 32'd1;
        end
        if (cnt_y == act_y) begin
          cnt_y <= '0;
          act_y <= nxt_y;
        end else begin
          cnt_y <= cnt_y + 32'd1;
        end
      end
    end
  end

  // Arbiter: one pulse per cycle; a waiting Y beats a fresh X, which then waits.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      move_pulses <= 4'b0000;
      pending     <= 1'b0;
      pend_x      <= 1'b0;
      pend_x_dir  <= 1'b0;
      pend_y_dir  <= 1'b0;
    end else begin
      move_pulses <= 4'b0000;
      if (pending) begin
        move_pulses <= pend_y_dir ? 4'b1000 : 4'b0100;
        pending     <= req_y;
        pend_y_dir  <= sign_y;
        pend_x      <= pend_x | req_x;
        if (req_x) pend_x_dir <= sign_x;
      end else if (pend_x) begin
        move_pulses <= pend_x_dir ? 4'b0010 : 4'b0001;
        pend_x      <= req_x;
        if (req_x) pend_x_dir <= sign_x;
        pending     <= req_y;
        pend_y_dir  <= sign_y;
      end else if (req_x) begin
        move_pulses <= sign_x ? 4'b0010 : 4'b0001;
        pending     <= req_y;
        pend_y_dir  <= sign_y;
      end else if (req_y) begin
        move_pulses <= sign_y ? 4'b1000 : 4'b0100;
      end
    end
  end

endmodule

// File: tb/tb_tilt_pulse_scheduler.sv
// Directed self-checking bench for tilt_pulse_scheduler (small clock, STAGGER=0).
module tb_tilt_pulse_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] accel_x_in;
  logic [8:0] accel_y_in;
  logic [3:0] x_thresh_level;
  logic [3:0] y_thresh_level;
  logic [3:0] move_pulses;
  logic       pending;

  int compared   = 0;
  int mismatched = 0;

  tilt_pulse_scheduler #(
    .DATA_W(9), .CLK_HZ(1000),
    .THRESH_1(12), .THRESH_2(20), .THRESH_3(28), .THRESH_4(40),
    .FREQ_1(10), .FREQ_2(20), .FREQ_3(50), .FREQ_4(100),
    .STAGGER(0), .HYST(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .accel_x_in(accel_x_in), .accel_y_in(accel_y_in),
    .x_thresh_level(x_thresh_level), .y_thresh_level(y_thresh_level),
    .move_pulses(move_pulses), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until a pulse appears (bounded); n = cycles taken, seen = 0 on timeout.
  task automatic wait_pulse(input int budget, output int n, output logic [3:0] seen);
    n    = 0;
    seen = 4'b0000;
    while (n < budget) begin
      step(1);
      n++;
      if (move_pulses !== 4'b0000) begin
        seen = move_pulses;
        return;
      end
    end
  endtask

  typedef struct {
    logic [8:0] sample;
    logic [3:0] exp;
  } vec_t;

  initial begin
    int         n;
    logic [3:0] seen;
    int         xs, ys, multi, pend_cnt, stray;
    vec_t       vecs[10];

    reset = 1'b1; enable = 1'b0; accel_x_in = 9'h0FF; accel_y_in = 9'h0FF;
    step(3);
    check("rst_move", 32'(move_pulses), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_xthr", 32'(x_thresh_level), 32'h0);
    check("rst_ythr", 32'(y_thresh_level), 32'h0);

    // Level 1 on X: exact 2-cycle latency, then +x every 100 cycles.
    reset = 1'b0; enable = 1'b1; accel_x_in = 9'h0F0;
    step(1);
    check("lat1_xthr", 32'(x_thresh_level), 32'h0);
    step(1);
    check("lat2_xthr", 32'(x_thresh_level), 32'h1);
    check("lat2_ythr", 32'(y_thresh_level), 32'h0);
    step(10);
    wait_pulse(200, n, seen);
    check("l1_sync_dir", 32'(seen), 32'h1);
    step(1);
    check("l1_single_cycle", 32'(move_pulses), 32'h0);
    wait_pulse(200, n, seen);
    check("l1_gap_a", 32'(n), 32'd99);
    check("l1_dir_a", 32'(seen), 32'h1);
    wait_pulse(200, n, seen);
    check("l1_gap_b", 32'(n), 32'd100);
    check("l1_dir_b", 32'(seen), 32'h1);

    // Mid-period change to level 4, sign 1: current period completes, then 10-cycle gaps.
    step(30);
    accel_x_in = 9'h130;
    wait_pulse(200, n, seen);
    check("chg_finish_gap", 32'(n), 32'd70);
    check("chg_dir", 32'(seen), 32'h2);
    check("l4_xthr", 32'(x_thresh_level), 32'hF);
    wait_pulse(50, n, seen);
    check("l4_gap_a", 32'(n), 32'd10);
    check("l4_dir_a", 32'(seen), 32'h2);
    wait_pulse(50, n, seen);
    check("l4_gap_b", 32'(n), 32'd10);

    // Both axes identical: every X tick collides with a Y tick.
    reset = 1'b1;
    step(1);
    reset = 1'b0; accel_x_in = 9'h130; accel_y_in = 9'h130;
    step(20);
    wait_pulse(50, n, seen);
    check("arb_x_first", 32'(seen), 32'h2);
    check("arb_pending_set", 32'(pending), 32'h1);
    step(1);
    check("arb_y_next", 32'(move_pulses), 32'h8);
    check("arb_pending_clr", 32'(pending), 32'h0);
    xs = 0; ys = 0; multi = 0; pend_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (move_pulses === 4'b0010) xs++;
      if (move_pulses === 4'b1000) ys++;
      if ($countones(move_pulses) > 1) multi++;
      if (pending === 1'b1) pend_cnt++;
    end
    check("arb_x_count", 32'(xs), 32'd100);
    check("arb_y_count", 32'(ys), 32'd100);
    check("arb_one_hot", 32'(multi), 32'd0);
    check("arb_pending_cycles", 32'(pend_cnt), 32'd100);

    // Dropping enable discards the pending Y and freezes the counters.
    wait_pulse(50, n, seen);
    check("en_gap", 32'(n), 32'd9);
    check("en_pending_before", 32'(pending), 32'h1);
    enable = 1'b0;
    step(1);
    check("en_off_move", 32'(move_pulses), 32'h0);
    check("en_off_pending", 32'(pending), 32'h0);
    step(5);
    check("en_off_hold", 32'(move_pulses), 32'h0);
    enable = 1'b1;
    step(1);
    check("en_no_stale_y", 32'(move_pulses), 32'h0);
    wait_pulse(50, n, seen);
    check("en_resume_gap", 32'(n), 32'd9);
    check("en_resume_dir", 32'(seen), 32'h2);
    check("en_resume_pending", 32'(pending), 32'h1);

    // Reset while a Y pulse is pending.
    reset = 1'b1;
    step(1);
    check("rp_move", 32'(move_pulses), 32'h0);
    check("rp_pending", 32'(pending), 32'h0);
    check("rp_xthr", 32'(x_thresh_level), 32'h0);
    check("rp_ythr", 32'(y_thresh_level), 32'h0);
    enable = 1'b0;
    step(1);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (move_pulses !== 4'b0000) stray++;
    end
    check("rp_no_pulse_after", 32'(stray), 32'd0);
    check("dis_levels_update", 32'(x_thresh_level), 32'hF);

    // Threshold boundaries and hysteresis, with pulses disabled.
    vecs[0] = '{9'h10B, 4'b0000};  // mag 11
    vecs[1] = '{9'h10C, 4'b0001};  // mag 12
    vecs[2] = '{9'h127, 4'b0111};  // mag 39
    vecs[3] = '{9'h128, 4'b1111};  // mag 40
    vecs[4] = '{9'h0EB, 4'b0011};  // sign 0, mag 20
    vecs[5] = '{9'h107, 4'b0000};  // mag 7
    vecs[6] = '{9'h113, 4'b0001};  // mag 19
    vecs[7] = '{9'h111, 4'b0001};  // mag 17
`ifdef TILT_HYST_EN
    vecs[8] = '{9'h10A, 4'b0001};  // mag 10 stays above 12-4
`else
    vecs[8] = '{9'h10A, 4'b0000};  // mag 10
`endif
    vecs[9] = '{9'h107, 4'b0000};  // mag 7
    for (int i = 0; i < 10; i++) begin
      accel_x_in = vecs[i].sample;
      step(2);
      check($sformatf("thr_x_%0d", i), 32'(x_thresh_level), 32'(vecs[i].exp));
    end
    accel_y_in = 9'h0D7;  // mag 40
    step(2);
    check("thr_y_40", 32'(y_thresh_level), 32'hF);
    accel_y_in = 9'h0F4;  // mag 11
    step(2);
    check("thr_y_11", 32'(y_thresh_level), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
